// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate and retire, out-of-order CDB completion,
// operand lookup with same-cycle CDB bypass, and a full flush when a mispredicted branch retires.
module reorder_buffer #(
    parameter int ROB_DEPTH = 16,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             alloc_valid,
    input  logic [4:0]       alloc_rd,
    input  logic [31:0]      alloc_pc,
    input  logic             alloc_is_branch,
    input  logic             alloc_pred_taken,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             rob_full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    input  logic             cdb_br_taken,
    input  logic [31:0]      cdb_br_target,
    input  logic [TAG_W-1:0] q1_tag,
    input  logic [TAG_W-1:0] q2_tag,
    output logic             q1_ready,
    output logic             q2_ready,
    output logic [31:0]      q1_value,
    output logic [31:0]      q2_value,
    output logic             commit_valid,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_value,
    output logic [TAG_W-1:0] commit_tag,
    output logic             flush,
    output logic [31:0]      flush_pc
);
    logic [TAG_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]       count_q, count_d;
    logic [ROB_DEPTH-1:0] busy_q, busy_d, ready_q, ready_d;
    logic [ROB_DEPTH-1:0] is_branch_q, is_branch_d, pred_taken_q, pred_taken_d;
    logic [ROB_DEPTH-1:0] br_taken_q, br_taken_d;
    logic [4:0]           rd_q [ROB_DEPTH];
    logic [4:0]           rd_d [ROB_DEPTH];
    logic [31:0]          pc_q [ROB_DEPTH];
    logic [31:0]          pc_d [ROB_DEPTH];
    logic [31:0]          value_q [ROB_DEPTH];
    logic [31:0]          value_d [ROB_DEPTH];
    logic [31:0]          br_target_q [ROB_DEPTH];
    logic [31:0]          br_target_d [ROB_DEPTH];

    logic                 commit_valid_q, commit_valid_d, flush_q, flush_d;
    logic [4:0]           commit_rd_q, commit_rd_d;
    logic [31:0]          commit_value_q, commit_value_d, flush_pc_q, flush_pc_d;
    logic [TAG_W-1:0]     commit_tag_q, commit_tag_d;

    logic                 commit_now, mispredict, accept_alloc, q1_hit, q2_hit;

    assign alloc_tag = tail_q;
    assign rob_full  = (count_q == (TAG_W+1)'(ROB_DEPTH));

    // Results on the CDB this cycle are forwarded before they land in the entry.
    assign q1_hit   = cdb_valid && (cdb_tag == q1_tag);
    assign q2_hit   = cdb_valid && (cdb_tag == q2_tag);
    assign q1_ready = busy_q[q1_tag] && (ready_q[q1_tag] || q1_hit);
    assign q2_ready = busy_q[q2_tag] && (ready_q[q2_tag] || q2_hit);
    assign q1_value = q1_hit ? cdb_value : value_q[q1_tag];
    assign q2_value = q2_hit ? cdb_value : value_q[q2_tag];

    assign commit_valid = commit_valid_q;
    assign commit_rd    = commit_rd_q;
    assign commit_value = commit_value_q;
    assign commit_tag   = commit_tag_q;
    assign flush        = flush_q;
    assign flush_pc     = flush_pc_q;

    assign commit_now   = (count_q != '0) && ready_q[head_q];
    assign mispredict   = commit_now && is_branch_q[head_q]
                          && (br_taken_q[head_q] != pred_taken_q[head_q]);
    assign accept_alloc = alloc_valid && !rob_full && !mispredict;

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        busy_d         = busy_q;
        ready_d        = ready_q;
        is_branch_d    = is_branch_q;
        pred_taken_d   = pred_taken_q;
        br_taken_d     = br_taken_q;
        rd_d           = rd_q;
        pc_d           = pc_q;
        value_d        = value_q;
        br_target_d    = br_target_q;
        commit_valid_d = 1'b0;
        commit_rd_d    = commit_rd_q;
        commit_value_d = commit_value_q;
        commit_tag_d   = commit_tag_q;
        flush_d        = 1'b0;
        flush_pc_d     = flush_pc_q;

        if (rdy) begin
            if (cdb_valid && busy_q[cdb_tag]) begin
                ready_d[cdb_tag]     = 1'b1;
                value_d[cdb_tag]     = cdb_value;
                br_taken_d[cdb_tag]  = cdb_br_taken;
                br_target_d[cdb_tag] = cdb_br_target;
            end
            if (accept_alloc) begin
                busy_d[tail_q]       = 1'b1;
                ready_d[tail_q]      = 1'b0;
                rd_d[tail_q]         = alloc_rd;
                pc_d[tail_q]         = alloc_pc;
                is_branch_d[tail_q]  = alloc_is_branch;
                pred_taken_d[tail_q] = alloc_pred_taken;
                tail_d               = tail_q + TAG_W'(1);
            end
            if (commit_now) begin
                busy_d[head_q] = 1'b0;
                head_d         = head_q + TAG_W'(1);
                commit_valid_d = 1'b1;
                commit_rd_d    = rd_q[head_q];
                commit_value_d = value_q[head_q];
                commit_tag_d   = head_q;
            end
            count_d = count_q + (TAG_W+1)'(accept_alloc) - (TAG_W+1)'(commit_now);
            // A mispredict overrides everything above, including any CDB write or allocation.
            if (mispredict) begin
                busy_d     = '0;
                ready_d    = '0;
                head_d     = '0;
                tail_d     = '0;
                count_d    = '0;
                flush_d    = 1'b1;
                flush_pc_d = br_taken_q[head_q] ? br_target_q[head_q] : pc_q[head_q] + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            busy_q         <= '0;
            ready_q        <= '0;
            is_branch_q    <= '0;
            pred_taken_q   <= '0;
            br_taken_q     <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rd_q[i]        <= '0;
                pc_q[i]        <= '0;
                value_q[i]     <= '0;
                br_target_q[i] <= '0;
            end
            commit_valid_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_value_q <= '0;
            commit_tag_q   <= '0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            is_branch_q    <= is_branch_d;
            pred_taken_q   <= pred_taken_d;
            br_taken_q     <= br_taken_d;
            rd_q           <= rd_d;
            pc_q           <= pc_d;
            value_q        <= value_d;
            br_target_q    <= br_target_d;
            commit_valid_q <= commit_valid_d;
            commit_rd_q    <= commit_rd_d;
            commit_value_q <= commit_value_d;
            commit_tag_q   <= commit_tag_d;
            flush_q        <= flush_d;
            flush_pc_q     <= flush_pc_d;
        end
    end
endmodule
